// File: rtl/conv_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : conv_relu_maxpool
// Brief    : FP16 ReLU followed by 2x2 stride-2 max pooling on a streamed
//            conv output, using a half-row line buffer of pair maxima.
// Revision : 1.0 - initial release
// ============================================================================
module conv_relu_maxpool #(
    parameter int IMG_W = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_clear,
    output logic [15:0] o_data,
    output logic        o_valid
);

    localparam int               c_HALF  = IMG_W / 2;
    localparam int               c_IDX_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(IMG_W - 1);

    logic [CNT_W-1:0]   r_col;
    logic               r_row_odd;
    logic [15:0]        r_pair_max;
    logic [15:0]        r_line [c_HALF];

    logic               w_accept;
    logic [15:0]        w_relu;
    logic [15:0]        w_pair;
    logic [15:0]        w_buf;
    logic [15:0]        w_win;
    logic [c_IDX_W-1:0] w_idx;

    // Post-ReLU values are non-negative, so bits 14:0 order them as unsigned.
    assign w_accept = i_valid & ~i_clear;
    assign w_relu   = i_data[15] ? 16'h0000 : i_data;
    assign w_pair   = (w_relu[14:0] > r_pair_max[14:0]) ? w_relu : r_pair_max;
    assign w_idx    = c_IDX_W'(r_col >> 1);
    assign w_buf    = r_line[w_idx];
    assign w_win    = (w_buf[14:0] > w_pair[14:0]) ? w_buf : w_pair;

    // Buffer is always rewritten on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (rst && w_accept && r_col[0] && !r_row_odd) begin
            r_line[w_idx] <= w_pair;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col      <= '0;
            r_row_odd  <= 1'b0;
            r_pair_max <= 16'h0000;
            o_data     <= 16'h0000;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                r_col     <= '0;
                r_row_odd <= 1'b0;
            end else if (i_valid) begin
                if (r_col == c_LAST) begin
                    r_col     <= '0;
                    r_row_odd <= ~r_row_odd;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0]) begin
                    r_pair_max <= w_relu;
                end else if (r_row_odd) begin
                    o_data  <= w_win;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_relu_maxpool
// Brief    : Directed self-checking bench for conv_relu_maxpool (IMG_W=4 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_relu_maxpool;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] d4  = 16'h0000;
    logic        v4  = 1'b0;
    logic [15:0] d8  = 16'h0000;
    logic        v8  = 1'b0;
    logic [15:0] od4, od8;
    logic        ov4, ov8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_relu_maxpool #(.IMG_W(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .i_data(d4), .i_valid(v4), .i_clear(clr),
        .o_data(od4), .o_valid(ov4)
    );

    conv_relu_maxpool #(.IMG_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .i_data(d8), .i_valid(v8), .i_clear(clr),
        .o_data(od8), .o_valid(ov8)
    );

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic use8, input logic [15:0] d, input logic v,
                        input logic c, input logic exp_v, input logic [15:0] exp_d,
                        input string tag);
        @(negedge clk);
        clr = c;
        if (use8) begin d8 = d; v8 = v; end
        else      begin d4 = d; v4 = v; end
        @(posedge clk);
        #1;
        if (use8) begin
            check1({tag, ".valid"}, ov8, exp_v);
            if (exp_v) check16({tag, ".data"}, od8, exp_d);
        end else begin
            check1({tag, ".valid"}, ov4, exp_v);
            if (exp_v) check16({tag, ".data"}, od4, exp_d);
        end
        clr = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b0; v4 = 1'b0; v8 = 1'b0;
            @(posedge clk);
            #1;
            check1("rst.valid4", ov4, 1'b0);
            check16("rst.data4", od4, 16'h0000);
            check1("rst.valid8", ov8, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
    endtask

    logic [15:0] basic [8];
    logic [15:0] basic_exp [8];
    logic        basic_v [8];

    initial begin
        basic     = '{16'h3C00, 16'h4000, 16'hBC00, 16'h4200,
                      16'h4400, 16'h3800, 16'hC000, 16'h8000};
        basic_v   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        basic_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4400, 16'h0, 16'h4200};

        do_reset(2);

        // Basic two-window frame
        for (int i = 0; i < 8; i++)
            step(1'b0, basic[i], 1'b1, 1'b0, basic_v[i], basic_exp[i], "basic");
        idle("basic.after");
        check16("basic.hold", od4, 16'h4200);

        // Negative window ReLUs to zero; second window is positive
        step(1'b0, 16'hBC00, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r0c0");
        step(1'b0, 16'hC000, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r0c1");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r0c2");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r0c3");
        step(1'b0, 16'hC200, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r1c0");
        step(1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 16'h0000, "neg.r1c1");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "neg.r1c2");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b1, 16'h3C00, "neg.r1c3");

        // Basic frame again with random idle gaps
        for (int i = 0; i < 8; i++) begin
            int gap;
            step(1'b0, basic[i], 1'b1, 1'b0, basic_v[i], basic_exp[i], "gaps");
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle("gaps.idle");
        end
        idle("gaps.after");

        // Reset mid-row discards the partial frame
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "mid.r0c0");
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "mid.r0c1");
        step(1'b0, 16'hBC00, 1'b1, 1'b0, 1'b0, 16'h0000, "mid.r0c2");
        do_reset(2);
        step(1'b0, 16'h3800, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r0c0");
        step(1'b0, 16'h3400, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r0c1");
        step(1'b0, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r0c2");
        step(1'b0, 16'h2C00, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r0c3");
        step(1'b0, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r1c0");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b1, 16'h3C00, "fresh.r1c1");
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "fresh.r1c2");
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000, "fresh.r1c3");

        // Clear wins over the sample completing the second window
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r0c0");
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r0c1");
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r0c2");
        step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r0c3");
        step(1'b0, 16'h4400, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r1c0");
        step(1'b0, 16'h4400, 1'b1, 1'b0, 1'b1, 16'h4400, "clr.r1c1");
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "clr.r1c2");
        step(1'b0, 16'h4800, 1'b1, 1'b1, 1'b0, 16'h0000, "clr.r1c3");
        idle("clr.after");
        check16("clr.hold", od4, 16'h4400);
        step(1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r0c0");
        step(1'b0, 16'h3800, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r0c1");
        step(1'b0, 16'h3400, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r0c2");
        step(1'b0, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r0c3");
        step(1'b0, 16'h2C00, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r1c0");
        step(1'b0, 16'h2800, 1'b1, 1'b0, 1'b1, 16'h3C00, "new.r1c1");
        step(1'b0, 16'h2400, 1'b1, 1'b0, 1'b0, 16'h0000, "new.r1c2");
        step(1'b0, 16'h2000, 1'b1, 1'b0, 1'b1, 16'h3400, "new.r1c3");
        idle("new.after");

        // IMG_W=8, four rows of increasing values: max is bottom-right sample
        for (int n = 0; n < 32; n++) begin
            logic ev;
            logic [15:0] val;
            val = 16'h3C00 + 16'(n);
            ev  = ((n / 8) % 2 == 1) && (n % 2 == 1);
            step(1'b1, val, 1'b1, 1'b0, ev, val, "w8");
        end
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, "w8.after");
        check16("w8.hold", od8, 16'h3C1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_relu_maxpool.md
CONV_RELU_MAXPOOL -- requirements
Module: conv_relu_maxpool

Interface
REQ-001 SHALL take parameter IMG_W, default 8, the conv output row width in pixels (even, >= 2).
REQ-002 SHALL take parameter CNT_W, default 8, the column counter width (2^CNT_W > IMG_W).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_data, input, 16 bits: FP16 conv result, the conv stage's o_data.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data valid this cycle, the conv stage's o_valid.
REQ-007 SHALL have port i_clear, input, 1 bit: synchronous frame restart.
REQ-008 SHALL have port o_data, output, 16 bits: FP16 pooled result.
REQ-009 SHALL have port o_valid, output, 1 bit: o_data valid, one-cycle pulse per pooled pixel.

Function
REQ-010 SHALL apply ReLU on every accepted sample: sign bit 1 -> 0x0000 (covers -0, negatives, negative NaN/Inf); sign bit 0 -> unchanged.
REQ-011 SHALL compare post-ReLU values as unsigned 15-bit magnitudes (bits 14:0); the larger is the max, ties keep either (bit-identical).
REQ-012 SHALL accept a sample only when i_valid=1; when i_valid=0, counters, buffer and partial max SHALL hold.
REQ-013 SHALL keep column counter col (0..IMG_W-1), incremented per accepted sample and wrapping to 0 after IMG_W-1, and toggle row parity on wrap.
REQ-014 SHALL, on an even col, register the sample as pair_max.
REQ-015 SHALL, on an odd col in an even row, write max(pair_max, sample) into line buffer entry col/2 (IMG_W/2 entries x 16 bits).
REQ-016 SHALL, on an odd col in an odd row, compute max(pair_max, sample, buffer[col/2]), register it into o_data, and assert o_valid on the next cycle.
REQ-017 SHALL have latency of exactly 1 cycle from the accepting edge of the window's 4th sample to o_valid=1.
REQ-018 SHALL produce IMG_W/2 outputs per row pair, in column order, and no output on even rows.
REQ-019 SHALL deassert o_valid on every cycle without a completed window; o_data SHALL hold its last value while o_valid=0.
REQ-020 SHALL apply no backpressure; at most one output occurs per 4 accepted inputs, so no output buffering is required.
REQ-021 SHALL, when i_clear=1, set col=0, row parity=even and o_valid=0 the next cycle; i_clear SHALL win over a simultaneous i_valid (that sample is dropped).
REQ-022 SHALL let an o_valid pulse already scheduled by an accepting edge be suppressed if i_clear is asserted on the following edge.
REQ-023 SHALL NOT require clearing of buffer contents, since they are always rewritten in an even row before being read.

Reset
REQ-024 SHALL, while rst=0 at a rising edge, set o_data=0x0000, o_valid=0, col=0, row parity=even, pair_max=0x0000.
REQ-025 SHALL, on reset asserted mid-row, discard the partial row pair; the first sample after rst returns to 1 SHALL be treated as row 0, col 0.
REQ-026 SHALL give rst priority over i_clear and i_valid.

Verification
REQ-027 SHALL verify, with IMG_W=4, row0 = 0x3C00,0x4000,0xBC00,0x4200 and row1 = 0x4400,0x3800,0xC000,0x8000 -> o_valid pulses with 0x4400, then 0x4200, each 1 cycle after row1 col1 / col3.
REQ-028 SHALL verify that a window of all-negative values (0xBC00,0xC000,0xC200,0x8000) -> o_data=0x0000 with o_valid=1.
REQ-029 SHALL verify that the scenario of REQ-027 with random i_valid gaps of 0-3 cycles gives identical outputs in the same order, with o_valid never high during gaps except the 1-cycle latency slot.
REQ-030 SHALL verify that rst=0 after row0 col2, then a fresh 8-sample frame, -> outputs computed from the fresh frame only, and o_valid=0 during reset.
REQ-031 SHALL verify that i_clear together with i_valid on row1 col3 -> no output for that window, and the next 8 samples form a new valid window pair.
REQ-032 SHALL verify, with IMG_W=8 and 4 rows of increasing values 0x3C00+n, 8 outputs, each equal to the bottom-right sample of its window.
